mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a shared-memory, multicycle variant of the team's 32-bit MIPS datapath. One instruction takes 3–5 states.
- Drives all datapath selects, write enables and the ALU operation from Op/Funct and the ALU Zero flag.
- Stalls on a memory ready handshake so the datapath can sit behind a slow unified instruction/data memory.
- Sits beside the datapath and replaces the single-cycle combinational control unit.

Parameters:
- RST_STATE, 4'd0: state entered on reset (FETCH); kept as a parameter for bring-up only.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- Op  in  6  Instr[31:26] from the instruction register.
- Funct  in  6  Instr[5:0].
- Zero  in  1  ALU zero flag; combinational in the current cycle.
- MemReady  in  1  memory has completed the current read or write this cycle.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  0 = rt, 1 = rd.
- MemtoReg  out  1  0 = ALUOut, 1 = Data register.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- PCEn  out  1  PC register load enable.
- IllegalOp  out  1  one-cycle pulse in DECODE when Op is unsupported.
- State  out  4  current state, for debug and bench.

Behaviour:
- State is a 4-bit register updated on posedge CLK, cleared asynchronously to FETCH while rst=0.
- While rst=0, MemWrite, IRWrite, RegWrite and PCEn are forced to 0 regardless of state. All other outputs show their FETCH values.
- States and encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
  - Codes 12–15 are unreachable; if entered, go to FETCH next cycle with all enables 0.
- Default output values in every state: all enables 0, selects 0, ALUControl = 010.
- FETCH:
  - Outputs: IorD=0, ALUSrcA=0, ALUSrcB=01, PCSrc=00, ALUControl=010.
  - IRWrite = PCEn = MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut).
  - Next state by Op:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → EXEC
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JUMP
    - anything else → FETCH, with IllegalOp=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next state is MEMRD if Op=lw, else MEMWR.
- MEMRD: IorD=1. Stay while MemReady=0; go to MEMWB on MemReady=1.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state FETCH.
- MEMWR: IorD=1, MemWrite=1 held for as long as the state lasts. Stay while MemReady=0; go to FETCH on MemReady=1.
- EXEC:
  - ALUSrcA=1, ALUSrcB=00.
  - ALUControl decoded from Funct:
    - 100000 → 010
    - 100010 → 110
    - 100100 → 000
    - 100101 → 001
    - 101010 → 111
    - any other Funct → 010, with no error flag.
  - Next state ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCEn=Zero. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state FETCH.
- JUMP: PCSrc=10, PCEn=1. Next state FETCH.
- Latencies: lw 5 states, sw 4, R-type 4, addi 4, beq 3, j 3. Each MemReady stall adds one cycle.
- Outputs are combinational from State (plus Zero, MemReady and Funct where listed above). Nothing is registered on the output side.
- Reset asserted mid-instruction aborts it immediately; no partial write occurs after rst falls.
- Op and Funct are sampled in every state, not latched. The datapath's IR must stay stable after IRWrite.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined:
  - Op 000101 (bne) goes from DECODE to BRANCH.
  - In BRANCH, PCEn = Zero when Op=beq and PCEn = ~Zero when Op=bne.
  - IllegalOp is not raised for bne.
- Undefined: 000101 is treated as illegal (IllegalOp pulse, return to FETCH).

Test Plan:
- lw (Op=100011), MemReady=1 always → states 0,1,2,3,4,0. RegWrite=1, MemtoReg=1 only in state 4. IRWrite/PCEn=1 only in FETCH.
- sw (Op=101011), MemReady low for 3 cycles in MEMWR → MemWrite=1 for 4 consecutive cycles, then FETCH. RegWrite never asserted.
- R-type Funct=101010 → ALUControl=111 in EXEC. ALUWB gives RegDst=1, RegWrite=1. Funct=100010 gives 110.
- beq with Zero=1 → PCEn=1, PCSrc=01 in BRANCH. With Zero=0 → PCEn=0. Both return to FETCH.
- FETCH with MemReady=0 for 5 cycles → State stays 0 and IRWrite=PCEn=0 throughout. MemReady=1 → one-cycle IRWrite/PCEn pulse, then DECODE.
- rst driven low in the middle of MEMWR (MemWrite=1) → MemWrite=0 asynchronously and State=0. Op=111111 in DECODE → IllegalOp=1 for one cycle, then FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Moore-style control FSM for the shared-memory multicycle MIPS datapath.
//   It sequences FETCH/DECODE and the per-instruction execute states, and it
//   stalls on MemReady so that a slow unified memory can sit behind it.
//
// Optional feature macro: MIPS_CTRL_BNE_EN (adds bne through the BRANCH state).
//
// Ports
//   CLK, rst       clock; asynchronous active-low reset
//   Op, Funct      instruction fields from the IR (sampled every cycle)
//   Zero           ALU zero flag (combinational, current cycle)
//   MemReady       memory completed the current access this cycle
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn
//                  datapath controls, combinational from State/inputs
//   IllegalOp      one-cycle pulse in DECODE for an unsupported Op
//   State          current state code (debug)
module mips_multicycle_ctrl #(
    parameter logic [3:0] RST_STATE = 4'd0
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;

    // R-type Funct to ALU operation; unknown Funct silently falls back to add.
    function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
        logic [2:0] op;
        case (f)
            6'b100000: op = ALU_ADD;
            6'b100010: op = ALU_SUB;
            6'b100100: op = ALU_AND;
            6'b100101: op = ALU_OR;
            6'b101010: op = ALU_SLT;
            default:   op = ALU_ADD;
        endcase
        return op;
    endfunction

    // State register
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= state_t'(RST_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = FETCH;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        PCSrc      = 2'b00;
        PCEn       = 1'b0;
        IllegalOp  = 1'b0;

        case (state_q)
            FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCEn    = MemReady;
                state_d = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                // Precompute branch target into ALUOut.
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_d = BRANCH;
`endif
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        IllegalOp = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD    = 1'b1;
                state_d = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = MemReady ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_to_alu(Funct);
                state_d    = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
`ifdef MIPS_CTRL_BNE_EN
                PCEn       = (Op == OP_BNE) ? ~Zero : Zero;
`else
                PCEn       = Zero;
`endif
                state_d    = FETCH;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                PCSrc   = 2'b10;
                PCEn    = 1'b1;
                state_d = FETCH;
            end
            // Unreachable codes recover to FETCH with everything idle.
            default: begin
                state_d = FETCH;
            end
        endcase

        // During reset show FETCH selects with every enable held off,
        // so an aborted write or PC update cannot leak through.
        if (!rst) begin
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b01;
            ALUControl = ALU_ADD;
            PCSrc      = 2'b00;
            PCEn       = 1'b0;
            IllegalOp  = 1'b0;
        end
    end

    assign State = state_q;

endmodule
